// File: rtl/gnn_pkg.sv
// Shared types for the GNN result collector.
// Slot s = 2*node + out_idx.
package gnn_pkg;

  localparam int NUM_NODES = 4;
  localparam int NUM_OUTS  = 2;
  localparam int NUM_SLOTS = NUM_NODES * NUM_OUTS;

  typedef logic [2:0] slot_idx_t;

  typedef enum logic {
    COLLECT = 1'b0,
    STREAM  = 1'b1
  } coll_state_t;

endpackage

// File: rtl/gnn_slot_reg.sv
// One result slot: rise detect, data hold, valid bit.
// Flags an overflow for a rise it cannot accept.
module gnn_slot_reg #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  input  logic         rdy,
  input  logic         collect,
  input  logic         kill,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         valid,
  output logic         cap,
  output logic         ovf
);

  logic rdy_q;
  logic rise;

  assign rise = rdy & ~rdy_q;
  assign cap  = rise & ~valid & collect & ~kill;
  assign ovf  = rise & (valid | ~collect);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
      valid <= 1'b0;
      q     <= '0;
    end else begin
      rdy_q <= rdy;
      if (clr) begin
        valid <= 1'b0;
      end else if (cap) begin
        valid <= 1'b1;
        q     <= d;
      end
    end
  end

endmodule

// File: rtl/gnn_result_collector.sv
// Collects eight GNN output words and streams them
// as one frame over valid/ready.
module gnn_result_collector
  import gnn_pkg::*;
#(
  parameter int OUT_WIDTH      = 21,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_SLOTS-1:0][OUT_WIDTH-1:0] res_data,
  input  logic [NUM_SLOTS-1:0]                res_ready,
  output logic [OUT_WIDTH-1:0]                m_data,
  output logic [2:0]                          m_slot,
  output logic                                m_last,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic                                frame_done,
  output logic                                overflow_err,
  output logic                                timeout_err,
  input  logic                                err_clr
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  coll_state_t state;
  logic [CNT_W-1:0] cnt;

  logic [NUM_SLOTS-1:0][OUT_WIDTH-1:0] slot_q;
  logic [NUM_SLOTS-1:0] valid;
  logic [NUM_SLOTS-1:0] cap;
  logic [NUM_SLOTS-1:0] ovf;

  logic collect;
  logic tmo;
  logic last_acc;
  logic clr;
  logic full;

  assign collect  = (state == COLLECT);
  assign tmo      = collect & (|valid) &
                    (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign last_acc = ~collect & m_valid & m_ready & m_last;
  assign clr      = tmo | last_acc;
  assign full     = &(valid | cap);

  assign m_data = m_valid ? slot_q[m_slot] : '0;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    gnn_slot_reg #(.W(OUT_WIDTH)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .d       (res_data[s]),
      .rdy     (res_ready[s]),
      .collect (collect),
      .kill    (tmo),
      .clr     (clr),
      .q       (slot_q[s]),
      .valid   (valid[s]),
      .cap     (cap[s]),
      .ovf     (ovf[s])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      cnt        <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_slot     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (tmo || (|cap) || ~(|valid)) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          if (full && !tmo) begin
            state   <= STREAM;
            m_valid <= 1'b1;
            m_slot  <= '0;
            m_last  <= 1'b0;
            cnt     <= '0;
          end
        end
        STREAM: begin
          if (m_valid && m_ready) begin
            if (m_last) begin
              state      <= COLLECT;
              m_valid    <= 1'b0;
              m_last     <= 1'b0;
              m_slot     <= '0;
              frame_done <= 1'b1;
            end else begin
              m_slot <= m_slot + 3'd1;
              m_last <= (m_slot == 3'd6);
            end
          end
        end
      endcase
    end
  end

  // Setting an error beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (|ovf)         overflow_err <= 1'b1;
      else if (err_clr) overflow_err <= 1'b0;
      if (tmo)          timeout_err  <= 1'b1;
      else if (err_clr) timeout_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gnn_result_collector.sv
// Scoreboard bench for gnn_result_collector.
// Expected words queue at drive time, pop on accept.
module tb_gnn_result_collector;

  localparam int W = 21;
  localparam int T = 64;

  typedef struct {
    logic [W-1:0] d;
    logic [2:0]   s;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0][W-1:0] res_data;
  logic [7:0]        res_ready;
  logic [W-1:0]      m_data;
  logic [2:0]        m_slot;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;
  logic              frame_done;
  logic              overflow_err;
  logic              timeout_err;
  logic              err_clr;

  gnn_result_collector #(
    .OUT_WIDTH      (W),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .res_data     (res_data),
    .res_ready    (res_ready),
    .m_data       (m_data),
    .m_slot       (m_slot),
    .m_last       (m_last),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .frame_done   (frame_done),
    .overflow_err (overflow_err),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int fd_count = 0;
  int accepts = 0;
  int valid_seen = 0;

  ent_t         sb[$];
  logic [W-1:0] exp_s [8];

  task automatic check(string tag,
                       logic [31:0] obs,
                       logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(int s, logic [W-1:0] v);
    res_data[s]  = v;
    res_ready[s] = 1'b1;
    exp_s[s]     = v;
  endtask

  task automatic push_frame();
    for (int s = 0; s < 8; s++) begin
      sb.push_back('{exp_s[s], 3'(s)});
    end
  endtask

  task automatic wait_frames(int target, int budget,
                             bit toggle);
    int n = 0;
    while (fd_count < target && n < budget) begin
      if (toggle) m_ready = ~m_ready;
      tick();
      n++;
    end
    check("frame_wait", 32'(fd_count >= target), 1);
  endtask

  // Output monitor, sampled on the falling edge.
  bit           fd_exp = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic [2:0]   prev_slot;

  always @(negedge clk) begin
    if (!rst_n) begin
      fd_exp     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("frame_done", 32'(frame_done), 32'(fd_exp));
      if (frame_done) fd_count++;
      if (m_valid) valid_seen++;
      if (prev_stall) begin
        check("stall_data", 32'(m_data), 32'(prev_data));
        check("stall_slot", 32'(m_slot), 32'(prev_slot));
      end
      fd_exp = 1'b0;
      if (m_valid && m_ready) begin
        accepts++;
        if (sb.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          ent_t e;
          e = sb.pop_front();
          check("m_data", 32'(m_data), 32'(e.d));
          check("m_slot", 32'(m_slot), 32'(e.s));
          check("m_last", 32'(m_last), 32'(e.s == 3'd7));
          if (e.s == 3'd7) fd_exp = 1'b1;
        end
      end
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      prev_slot  = m_slot;
    end
  end

  initial begin
    int f0;
    int a0;
    rst_n     = 1'b0;
    res_data  = '0;
    res_ready = '0;
    m_ready   = 1'b0;
    err_clr   = 1'b0;
    repeat (2) tick();
    check("rst_valid", 32'(m_valid), 0);
    check("rst_slot", 32'(m_slot), 0);
    check("rst_data", 32'(m_data), 0);
    check("rst_errs", 32'({overflow_err, timeout_err}), 0);
    rst_n = 1'b1;
    tick();

    // 1: all flags together, free-flowing sink
    m_ready = 1'b1;
    f0 = fd_count;
    for (int s = 0; s < 8; s++) put(s, W'(s * 100 - 350));
    push_frame();
    tick();
    res_ready = '0;
    wait_frames(f0 + 1, 40, 1'b0);
    check("t1_errs", 32'({overflow_err, timeout_err}), 0);

    // 2: staggered rises, toggling sink
    f0 = fd_count;
    a0 = accepts;
    for (int i = 0; i < 8; i++) begin
      put(7 - i, W'(1000 + 17 * i));
      tick();
    end
    push_frame();
    res_ready = '0;
    wait_frames(f0 + 1, 60, 1'b1);
    check("t2_accepts", 32'(accepts - a0), 8);
    m_ready = 1'b1;

    // 3: extreme values, level-held flags
    f0 = fd_count;
    put(0, 21'h100000);
    put(1, 21'h0FFFFF);
    for (int s = 2; s < 8; s++) put(s, W'(-s));
    push_frame();
    repeat (20) tick();
    res_ready = '0;
    repeat (4) tick();
    check("t3_frames", 32'(fd_count - f0), 1);
    check("t3_ovf", 32'(overflow_err), 0);
    check("t3_idle", 32'(m_valid), 0);

    // 4: re-rise on a full slot
    f0 = fd_count;
    put(3, W'(5));
    tick();
    res_ready = '0;
    tick();
    res_data[3]  = W'(9);
    res_ready[3] = 1'b1;
    tick();
    res_ready = '0;
    tick();
    check("t4_ovf_set", 32'(overflow_err), 1);
    for (int s = 0; s < 8; s++) begin
      if (s != 3) put(s, W'(200 + s));
    end
    push_frame();
    tick();
    res_ready = '0;
    wait_frames(f0 + 1, 40, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_ovf_clr", 32'(overflow_err), 0);

    // 5: partial frame times out
    valid_seen = 0;
    for (int s = 0; s < 6; s++) put(s, W'(77));
    tick();
    res_ready = '0;
    repeat (T + 6) tick();
    check("t5_tmo", 32'(timeout_err), 1);
    check("t5_novalid", 32'(valid_seen), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t5_tmo_clr", 32'(timeout_err), 0);
    f0 = fd_count;
    for (int s = 0; s < 8; s++) put(s, W'(300 - 41 * s));
    push_frame();
    tick();
    res_ready = '0;
    wait_frames(f0 + 1, 40, 1'b0);
    check("t5_ovf", 32'(overflow_err), 0);

    // 6: reset while streaming slot 4
    for (int s = 0; s < 8; s++) put(s, W'(500 + s));
    push_frame();
    tick();
    res_ready = '0;
    begin
      int n = 0;
      while (!(m_valid && m_slot == 3'd4) && n < 30) begin
        tick();
        n++;
      end
      check("t6_reach4", 32'(m_slot), 4);
    end
    m_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("t6_valid", 32'(m_valid), 0);
    check("t6_slot", 32'(m_slot), 0);
    check("t6_last", 32'(m_last), 0);
    check("t6_data", 32'(m_data), 0);
    check("t6_fd", 32'(frame_done), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    tick();
    f0 = fd_count;
    for (int s = 0; s < 8; s++) put(s, W'(-(s * 3) - 1));
    push_frame();
    tick();
    res_ready = '0;
    wait_frames(f0 + 1, 40, 1'b0);
    check("t6_errs", 32'({overflow_err, timeout_err}), 0);
    check("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
